// File: rtl/mx_pkg.sv
// Shared MX types: BF16 field layout, E8M0 NaN encoding and the quantiser FSM states.
package mx_pkg;

    typedef struct packed {
        logic       sign;
        logic [7:0] exp;
        logic [6:0] man;
    } bf16_t;

    localparam logic [7:0] E8M0_NAN  = 8'hFF;
    localparam int         BF16_BIAS = 127;

    typedef enum logic [1:0] {
        FILL = 2'd0,
        CALC = 2'd1,
        EMIT = 2'd2
    } state_t;

endpackage

// File: rtl/mx_int_quant_elem.sv
// Combinational BF16 -> MXINT element: align to the block exponent, round, clamp, apply sign.
// Optional MX_QUANT_RNE_EN selects round-to-nearest-even; otherwise the magnitude is truncated.
module mx_int_quant_elem
    import mx_pkg::*;
#(
    parameter int elem_width = 8
) (
    input  bf16_t                  i_bf16,
    input  logic [7:0]             i_max_exp,
    output logic [elem_width-1:0]  o_elem
);

    localparam logic [8:0]            SH_ADJ     = 9'(9 - elem_width);
    localparam logic [8:0]            MAG_MAX    = 9'((1 << (elem_width - 1)) - 1);
    localparam logic [elem_width-1:0] MAG_MAX_EW = elem_width'((1 << (elem_width - 1)) - 1);

    logic [8:0]            sh;
    logic [8:0]            mag_rnd;
    logic [elem_width-1:0] mag_clamp;
`ifdef MX_QUANT_RNE_EN
    logic [16:0]           wide;
`endif

    always_comb begin
        // max_exp >= exp for every finite element, so the difference never wraps
        sh = {1'b0, i_max_exp - i_bf16.exp} + SH_ADJ;
`ifdef MX_QUANT_RNE_EN
        // Keep 9 bits below the binary point: guard at bit 8, sticky below it
        wide    = {1'b1, i_bf16.man, 9'd0} >> sh[3:0];
        mag_rnd = {1'b0, wide[16:9]} + 9'(wide[8] & ((|wide[7:0]) | wide[9]));
`else
        mag_rnd = {1'b0, 8'({1'b1, i_bf16.man} >> sh[3:0])};
`endif
        if (i_bf16.exp == 8'd0 || sh > 9'd9) begin
            mag_rnd = 9'd0;
        end
        mag_clamp = (mag_rnd > MAG_MAX) ? MAG_MAX_EW : mag_rnd[elem_width-1:0];
        o_elem    = i_bf16.sign ? -mag_clamp : mag_clamp;
    end

endmodule

// File: rtl/mx_bf16_quant_int.sv
// Streaming BF16 -> MXINT block quantiser: collects block_size inputs, emits shared E8M0 scale plus elements.
// Rounding mode of the element path is selected by MX_QUANT_RNE_EN (undefined: truncate).
module mx_bf16_quant_int
    import mx_pkg::*;
#(
    parameter int block_size = 32,
    parameter int elem_width = 8
) (
    input  logic                             i_clk,
    input  logic                             i_rst_n,
    input  logic [15:0]                      i_bf16,
    input  logic                             i_valid,
    output logic                             o_ready,
    output logic [7:0]                       o_scale,
    output logic [block_size*elem_width-1:0] o_elems,
    output logic                             o_valid,
    input  logic                             i_ready
);

    localparam int CW = (block_size > 1) ? $clog2(block_size) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(block_size - 1);

    state_t                           state_q, state_d;
    logic [CW-1:0]                    count_q, count_d;
    logic [7:0]                       max_exp_q, max_exp_d;
    logic                             special_q, special_d;
    logic [7:0]                       scale_q, scale_d;
    logic [block_size*elem_width-1:0] elems_q, elems_d;
    bf16_t                            buf_q [block_size];

    bf16_t                            in_w;
    logic                             in_fire;
    logic [block_size*elem_width-1:0] elem_w;

    assign in_w    = i_bf16;
    assign o_ready = (state_q == FILL);
    assign o_valid = (state_q == EMIT);
    assign in_fire = i_valid && o_ready;
    assign o_scale = scale_q;
    assign o_elems = elems_q;

    generate
        for (genvar gi = 0; gi < block_size; gi++) begin : g_elem
            mx_int_quant_elem #(
                .elem_width (elem_width)
            ) u_elem (
                .i_bf16    (buf_q[gi]),
                .i_max_exp (max_exp_q),
                .o_elem    (elem_w[gi*elem_width +: elem_width])
            );
        end
    endgenerate

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        max_exp_d = max_exp_q;
        special_d = special_q;
        scale_d   = scale_q;
        elems_d   = elems_q;
        case (state_q)
            FILL: begin
                if (in_fire) begin
                    if (count_q == LAST_IDX) begin
                        count_d = '0;
                        state_d = CALC;
                    end else begin
                        count_d = count_q + CW'(1);
                    end
                    // Inf/NaN poison the block; they never take part in the max
                    if (in_w.exp == 8'hFF) begin
                        special_d = 1'b1;
                    end else if (in_w.exp > max_exp_q) begin
                        max_exp_d = in_w.exp;
                    end
                end
            end
            CALC: begin
                scale_d = special_q ? E8M0_NAN : max_exp_q;
                elems_d = special_q ? '0 : elem_w;
                state_d = EMIT;
            end
            EMIT: begin
                if (i_ready) begin
                    state_d   = FILL;
                    max_exp_d = 8'd0;
                    special_d = 1'b0;
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= FILL;
            count_q   <= '0;
            max_exp_q <= 8'd0;
            special_q <= 1'b0;
            scale_q   <= 8'd0;
            elems_q   <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            max_exp_q <= max_exp_d;
            special_q <= special_d;
            scale_q   <= scale_d;
            elems_q   <= elems_d;
        end
    end

    // Element storage needs no reset: every slot is rewritten before the next CALC
    always_ff @(posedge i_clk) begin
        if (in_fire) begin
            buf_q[count_q] <= in_w;
        end
    end

endmodule

// File: tb/tb_mx_bf16_quant_int.sv
// Bench for mx_bf16_quant_int: directed vector table, handshake/reset sequences and randomized blocks vs a real-arithmetic model.
module tb_mx_bf16_quant_int;

    localparam int BS = 32;

    typedef logic [15:0] blk_t [BS];

    typedef struct packed {
        logic [15:0] v0;
        logic [15:0] v1;
        logic [15:0] v5;
        logic [15:0] vr;
        logic [7:0]  scale;
        logic [7:0]  e0;
        logic [7:0]  e1;
        logic [7:0]  e5;
        logic [7:0]  er;
    } vec_t;

`ifdef MX_QUANT_RNE_EN
    localparam logic [7:0] T3_E1 = 8'd18;
`else
    localparam logic [7:0] T3_E1 = 8'd17;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [15:0]       bf16 = 16'h0;
    logic              in_valid = 1'b0;
    logic              out_ready = 1'b0;
    logic              rdy8, vld8, rdy4, vld4;
    logic [7:0]        scale8, scale4;
    logic [BS*8-1:0]   elems8;
    logic [BS*4-1:0]   elems4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mx_bf16_quant_int #(.block_size(BS), .elem_width(8)) dut8 (
        .i_clk(clk), .i_rst_n(rst_n), .i_bf16(bf16), .i_valid(in_valid), .o_ready(rdy8),
        .o_scale(scale8), .o_elems(elems8), .o_valid(vld8), .i_ready(out_ready)
    );

    mx_bf16_quant_int #(.block_size(BS), .elem_width(4)) dut4 (
        .i_clk(clk), .i_rst_n(rst_n), .i_bf16(bf16), .i_valid(in_valid), .o_ready(rdy4),
        .o_scale(scale4), .o_elems(elems4), .o_valid(vld4), .i_ready(out_ready)
    );

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Element value = x / 2^(scale-127) * 2^(ew-2), then rounded, clamped symmetric and signed
    function automatic int ref_elem(input logic [15:0] x, input int maxe, input int ew);
        int  e;
        int  p;
        int  q;
        int  lim;
        real v;
        real fr;
        e = int'(x[14:7]);
        if (e == 0) return 0;
        v = real'(128 + int'(x[6:0]));
        p = (ew - 2) - 7 - (maxe - e);
        for (int i = 0; i < -p; i++) v = v / 2.0;
        for (int i = 0; i < p; i++) v = v * 2.0;
        q  = $rtoi(v);
        fr = v - real'(q);
`ifdef MX_QUANT_RNE_EN
        if (fr > 0.5 || (fr == 0.5 && (q % 2) == 1)) q++;
`else
        if (fr < 0.0) q = 0;
`endif
        lim = (1 << (ew - 1)) - 1;
        if (q > lim) q = lim;
        return x[15] ? -q : q;
    endfunction

    function automatic bit ref_special(input blk_t b);
        for (int k = 0; k < BS; k++) if (b[k][14:7] == 8'hFF) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int ref_maxexp(input blk_t b);
        int m = 0;
        for (int k = 0; k < BS; k++)
            if (b[k][14:7] != 8'hFF && int'(b[k][14:7]) > m) m = int'(b[k][14:7]);
        return m;
    endfunction

    task automatic check_model(input string name, input blk_t b);
        bit sp;
        int maxe;
        int req;
        int act;
        int nm;
        int first;
        sp   = ref_special(b);
        maxe = ref_maxexp(b);
        chk({name, " scale8"}, int'(scale8), sp ? 255 : maxe);
        chk({name, " scale4"}, int'(scale4), sp ? 255 : maxe);
        for (int w = 8; w >= 4; w -= 4) begin
            nm = 0;
            first = -1;
            for (int k = 0; k < BS; k++) begin
                req = sp ? 0 : ref_elem(b[k], maxe, w);
                act = (w == 8) ? int'($signed(elems8[k*8 +: 8])) : int'($signed(elems4[k*4 +: 4]));
                if (act != req) begin
                    nm++;
                    if (first < 0) first = k;
                end
            end
            checks++;
            if (nm != 0) begin
                errors++;
                req = sp ? 0 : ref_elem(b[first], maxe, w);
                act = (w == 8) ? int'($signed(elems8[first*8 +: 8])) : int'($signed(elems4[first*4 +: 4]));
                $display("FAIL %s elems w=%0d: %0d wrong, elem %0d actual=%0d required=%0d",
                         name, w, nm, first, act, req);
            end
        end
    endtask

    task automatic send(input blk_t b, input int n, input int gap_max);
        int w;
        for (int k = 0; k < n; k++) begin
            if (k > 0) begin
                repeat ($urandom_range(gap_max, 0)) begin
                    in_valid = 1'b0;
                    @(posedge clk); #1;
                end
            end
            bf16 = b[k];
            in_valid = 1'b1;
            w = 0;
            while (!rdy8 && w < 200) begin
                @(posedge clk); #1;
                w++;
            end
            if (w >= 200) begin
                chk("o_ready timeout", int'(rdy8), 1);
                in_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    // Called right after the last input transfer: o_valid must appear exactly one edge later
    task automatic wait_valid(input string name);
        int w = 0;
        chk({name, " valid early"}, int'(vld8), 0);
        while (!vld8 && w < 20) begin
            @(posedge clk); #1;
            w++;
        end
        chk({name, " latency"}, w, 1);
        chk({name, " vld4"}, int'(vld4), 1);
        chk({name, " ready low in EMIT"}, int'(rdy8), 0);
    endtask

    task automatic release_blk(input string name, input int delay);
        logic [7:0]      s_cap;
        logic [BS*8-1:0] e_cap;
        s_cap = scale8;
        e_cap = elems8;
        repeat (delay) begin
            @(posedge clk); #1;
        end
        if (delay > 0)
            chk({name, " held stable"}, int'(vld8 && !rdy8 && scale8 == s_cap && elems8 == e_cap), 1);
        $display("block %s scale=0x%02h elem0=0x%02h ready_delay=%0d", name, scale8, elems8[7:0], delay);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({name, " valid drop"}, int'(vld8), 0);
        chk({name, " ready back"}, int'(rdy8), 1);
    endtask

    function automatic logic [15:0] rand_bf16(input int base, input int spread, input bit allow_sp);
        int r;
        int e;
        logic [15:0] x;
        r = int'($urandom_range(99, 0));
        x = 16'($urandom);
        if (r < 8) begin
            x[14:7] = 8'h00;
        end else if (allow_sp && r < 10) begin
            x[14:7] = 8'hFF;
        end else begin
            e = base + int'($urandom_range(2 * spread, 0)) - spread;
            if (e < 1) e = 1;
            if (e > 254) e = 254;
            x[14:7] = 8'(e);
        end
        return x;
    endfunction

    vec_t vecs [6];
    blk_t blk;
    blk_t nxt;

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int nm;
        string nm_s;

        vecs[0] = '{16'h3F80, 16'h3F80, 16'h3F80, 16'h3F80, 8'h7F, 8'h40, 8'h40, 8'h40, 8'h40};
        vecs[1] = '{16'h4000, 16'h3F80, 16'hBFC0, 16'h3F80, 8'h80, 8'h40, 8'h20, 8'hD0, 8'h20};
        vecs[2] = '{16'h4080, 16'h3F8C, 16'h0000, 16'h0000, 8'h81, 8'h40, T3_E1, 8'h00, 8'h00};
        vecs[3] = '{16'h3FFF, 16'hBFFF, 16'h0000, 16'h0000, 8'h7F, 8'h7F, 8'h81, 8'h00, 8'h00};
        vecs[4] = '{16'h7FC0, 16'h3F80, 16'h3F80, 16'h3F80, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00};
        vecs[5] = '{16'h3F80, 16'h3F80, 16'h3F80, 16'h3F80, 8'h7F, 8'h40, 8'h40, 8'h40, 8'h40};

        #1;
        chk("reset o_ready", int'(rdy8), 1);
        chk("reset o_valid", int'(vld8), 0);
        chk("reset o_scale", int'(scale8), 0);
        chk("reset o_elems", int'(|elems8), 0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++) begin
            nm_s = $sformatf("dir%0d", i + 1);
            for (int k = 0; k < BS; k++) blk[k] = vecs[i].vr;
            blk[0] = vecs[i].v0;
            blk[1] = vecs[i].v1;
            blk[5] = vecs[i].v5;
            send(blk, BS, 0);
            wait_valid(nm_s);
            chk({nm_s, " scale"}, int'(scale8), int'(vecs[i].scale));
            chk({nm_s, " e0"}, int'(elems8[7:0]), int'(vecs[i].e0));
            chk({nm_s, " e1"}, int'(elems8[15:8]), int'(vecs[i].e1));
            chk({nm_s, " e5"}, int'(elems8[47:40]), int'(vecs[i].e5));
            nm = 0;
            for (int k = 2; k < BS; k++)
                if (k != 5 && elems8[k*8 +: 8] != vecs[i].er) nm++;
            chk({nm_s, " rest mismatches"}, nm, 0);
            if (i == 0) begin
                nm = 0;
                for (int k = 0; k < BS; k++) if (elems4[k*4 +: 4] != 4'h4) nm++;
                chk("dir1 ew4 mismatches", nm, 0);
            end
            check_model(nm_s, blk);
            release_blk(nm_s, 0);
        end

        // Stall in EMIT, then release
        for (int k = 0; k < BS; k++) blk[k] = 16'h3F80;
        send(blk, BS, 0);
        wait_valid("hs");
        release_blk("hs", 5);

        // Async reset while EMIT: o_valid and outputs drop without a clock edge
        send(blk, BS, 0);
        wait_valid("rst_emit");
        #2 rst_n = 1'b0;
        #1;
        chk("rst_emit o_valid", int'(vld8), 0);
        chk("rst_emit o_scale", int'(scale8), 0);
        chk("rst_emit o_elems", int'(|elems8), 0);
        chk("rst_emit o_ready", int'(rdy8), 1);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Reset mid-fill: partial NaN block must not leak into the next block
        for (int k = 0; k < BS; k++) nxt[k] = 16'h7FC0;
        send(nxt, 10, 0);
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        send(blk, BS, 0);
        wait_valid("rst_fill");
        chk("rst_fill scale", int'(scale8), 8'h7F);
        check_model("rst_fill", blk);
        release_blk("rst_fill", 0);

        // Randomized blocks; next block's first element is offered during CALC/EMIT
        for (int k = 0; k < BS; k++) blk[k] = rand_bf16(127, 6, 1'b0);
        for (int b = 0; b < 30; b++) begin
            for (int k = 0; k < BS; k++)
                nxt[k] = rand_bf16(int'($urandom_range(200, 20)), (b % 3 == 0) ? 20 : 5, (b % 5 == 4));
            nm_s = $sformatf("rnd%0d", b);
            send(blk, BS, 2);
            bf16 = nxt[0];
            in_valid = 1'b1;
            wait_valid(nm_s);
            check_model(nm_s, blk);
            release_blk(nm_s, int'($urandom_range(3, 0)));
            blk = nxt;
        end
        in_valid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
